// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch run-control stage.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    localparam int SW_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int SW_LONG_PRESS_CYCLES = 100_000_000;

    // Counter width able to hold n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, counting debouncer and rising-edge press pulse
// for one raw push-button.
module button_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;

    // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_d  <= db;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = db;
    assign press = db & ~db_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run-control FSM for the stopwatch counter: IDLE/RUNNING/PAUSED plus clear.
// Optional long-press clear on start/stop enabled by STOPWATCH_LONG_PRESS_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = SW_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = SW_LONG_PRESS_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_reset,
    output logic       running,
    output logic       clear,
    output logic       start_stop_pulse,
    output logic [1:0] state
);

    logic ss_level;
    logic ss_press;
    logic rb_level;
    logic rb_press;
    logic long_event;
    logic clear_req;

    sw_state_t state_q;
    sw_state_t state_d;
    logic      running_q;
    logic      running_d;
    logic      clear_q;
    logic      clear_d;
    logic      pulse_q;
    logic      pulse_d;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_start_stop (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_start_stop),
        .level(ss_level),
        .press(ss_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_reset (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_reset),
        .level(rb_level),
        .press(rb_press)
    );

    logic unused_levels;
    assign unused_levels = ss_level ^ rb_level;

`ifdef STOPWATCH_LONG_PRESS_EN
    localparam int HW = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hold_cnt;
    logic          hold_fired;

    // Saturating hold counter; hold_fired limits the clear to once per press
    always_ff @(posedge clk) begin
        if (reset || !ss_level) begin
            hold_cnt   <= '0;
            hold_fired <= 1'b0;
        end else begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (long_event) begin
                hold_fired <= 1'b1;
            end
        end
    end

    assign long_event = ss_level && (hold_cnt == HOLD_LAST) && !hold_fired;
`else
    localparam int unused_long_press = LONG_PRESS_CYCLES;
    assign long_event = 1'b0;
`endif

    assign clear_req = rb_press | long_event;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            clear_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            clear_q   <= clear_d;
            pulse_q   <= pulse_d;
        end
    end

    // A clear request overrides any simultaneous start/stop press
    always_comb begin
        state_d = state_q;
        if (clear_req) begin
            state_d = IDLE;
        end else if (ss_press) begin
            case (state_q)
                IDLE:    state_d = RUNNING;
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        clear_d   = clear_req;
        pulse_d   = ss_press;
        running_d = (state_d == RUNNING);
    end

    assign running          = running_q;
    assign clear            = clear_q;
    assign start_stop_pulse = pulse_q;
    assign state            = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20; long-press expectations follow STOPWATCH_LONG_PRESS_EN.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start_stop;
    logic       btn_reset;
    logic       running;
    logic       clear;
    logic       start_stop_pulse;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;
    int tick_idx;
    int ss_count;
    int clr_count;
    int first_ss;
    int first_clr;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .btn_start_stop  (btn_start_stop),
        .btn_reset       (btn_reset),
        .running         (running),
        .clear           (clear),
        .start_stop_pulse(start_stop_pulse),
        .state           (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic markTime();
        tick_idx  = 0;
        ss_count  = 0;
        clr_count = 0;
        first_ss  = -1;
        first_clr = -1;
    endtask

    // Tick k after markTime() samples just after edge N+k-1
    task automatic tick();
        @(posedge clk);
        #1;
        tick_idx++;
        if (start_stop_pulse === 1'b1) begin
            ss_count++;
            if (first_ss < 0) first_ss = tick_idx;
        end
        if (clear === 1'b1) begin
            clr_count++;
            if (first_clr < 0) first_clr = tick_idx;
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic rb, input int n);
        btn_start_stop = ss;
        btn_reset      = rb;
        repeat (n) tick();
    endtask

    initial begin
        reset          = 1'b1;
        btn_start_stop = 1'b0;
        btn_reset      = 1'b0;
        markTime();
        repeat (3) tick();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_clear", 32'(clear), 32'd0);
        checkOutput("rst_pulse", 32'(start_stop_pulse), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] first press: IDLE -> RUNNING");
        markTime();
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("p1_state_before", 32'(state), 32'd0);
        tick();
        checkOutput("p1_pulse", 32'(start_stop_pulse), 32'd1);
        checkOutput("p1_state", 32'(state), 32'd1);
        checkOutput("p1_running", 32'(running), 32'd1);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("p1_pulse_count", 32'(ss_count), 32'd1);
        checkOutput("p1_pulse_tick", 32'(first_ss), 32'd7);

        $display("[TB] second press: RUNNING -> PAUSED");
        markTime();
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("p2_state", 32'(state), 32'd2);
        checkOutput("p2_running", 32'(running), 32'd0);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("p2_pulse_count", 32'(ss_count), 32'd1);
        checkOutput("p2_pulse_tick", 32'(first_ss), 32'd7);

        $display("[TB] bouncing press: PAUSED -> RUNNING");
        markTime();
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("bn_no_early_pulse", 32'(ss_count), 32'd0);
        tick();
        checkOutput("bn_pulse_tick", 32'(first_ss), 32'd15);
        checkOutput("bn_state", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b0, 4);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("bn_pulse_count", 32'(ss_count), 32'd1);

        $display("[TB] simultaneous press while RUNNING");
        markTime();
        applyStimulus(1'b1, 1'b1, 7);
        checkOutput("sim_clear", 32'(clear), 32'd1);
        checkOutput("sim_pulse", 32'(start_stop_pulse), 32'd1);
        checkOutput("sim_state", 32'(state), 32'd0);
        checkOutput("sim_running", 32'(running), 32'd0);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("sim_clear_count", 32'(clr_count), 32'd1);
        checkOutput("sim_pulse_count", 32'(ss_count), 32'd1);
        checkOutput("sim_state_after", 32'(state), 32'd0);

        $display("[TB] clear button while IDLE");
        markTime();
        applyStimulus(1'b0, 1'b1, 7);
        checkOutput("idle_clear", 32'(clear), 32'd1);
        checkOutput("idle_state", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("idle_clear_count", 32'(clr_count), 32'd1);

        $display("[TB] reset during debounce, button held through release");
        markTime();
        applyStimulus(1'b1, 1'b0, 2);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("rd_no_pulse", 32'(ss_count), 32'd0);
        checkOutput("rd_state", 32'(state), 32'd0);
        reset = 1'b0;
        markTime();
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("rd_pulse_tick", 32'(first_ss), 32'd7);
        checkOutput("rd_state_after", 32'(state), 32'd1);
        checkOutput("rd_running", 32'(running), 32'd1);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 10);

        markTime();
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("back_to_idle", 32'(state), 32'd0);

        $display("[TB] start/stop held 40 cycles from IDLE");
        markTime();
        applyStimulus(1'b1, 1'b0, 7);
        checkOutput("lp_running", 32'(state), 32'd1);
        applyStimulus(1'b1, 1'b0, 18);
        checkOutput("lp_no_early_clear", 32'(clr_count), 32'd0);
        tick();
`ifdef STOPWATCH_LONG_PRESS_EN
        checkOutput("lp_clear", 32'(clear), 32'd1);
        checkOutput("lp_state_idle", 32'(state), 32'd0);
`else
        checkOutput("lp_clear", 32'(clear), 32'd0);
        checkOutput("lp_state_run", 32'(state), 32'd1);
`endif
        applyStimulus(1'b1, 1'b0, 14);
        applyStimulus(1'b0, 1'b0, 15);
        checkOutput("lp_pulse_count", 32'(ss_count), 32'd1);
`ifdef STOPWATCH_LONG_PRESS_EN
        checkOutput("lp_clear_count", 32'(clr_count), 32'd1);
        checkOutput("lp_clear_tick", 32'(first_clr), 32'd26);
        checkOutput("lp_final_state", 32'(state), 32'd0);
        checkOutput("lp_final_running", 32'(running), 32'd0);
`else
        checkOutput("lp_clear_count", 32'(clr_count), 32'd0);
        checkOutput("lp_final_state", 32'(state), 32'd1);
        checkOutput("lp_final_running", 32'(running), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-conditioning and run-control stage that sits directly upstream of the stopwatch counter. It synchronises and debounces the two raw push-buttons. It turns presses into single-cycle pulses and holds the IDLE/RUNNING/PAUSED state. Its `running` level and `clear` pulse are the counter's only start/stop and reset sources; no raw button reaches the counter.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles needed to accept a button change (10 ms at 100 MHz).
- `LONG_PRESS_CYCLES`, default 100_000_000: hold time on start/stop that forces a clear (1 s); used only with `LONG_PRESS_EN`.
- `clk`  in  1: 100 MHz FPGA clock; the block's only clock.
- `reset`  in  1: synchronous, active-high reset.
- `btn_start_stop`  in  1: raw, asynchronous, bouncing start/stop button; high = pressed.
- `btn_reset`  in  1: raw, asynchronous, bouncing clear button; high = pressed.
- `running`  out  1: level; counter advances while high.
- `clear`  out  1: one-cycle pulse; counter returns to 00.0.
- `start_stop_pulse`  out  1: one-cycle pulse per accepted start/stop press.
- `state`  out  2: current FSM state, encoded IDLE=0, RUNNING=1, PAUSED=2.

## Operation
- Each button path, in order:
  - 2-flop synchroniser.
  - Debouncer: counter `cnt` and debounced level `db`.
    - If the synchronised input equals `db`, `cnt` is forced to 0.
    - Otherwise `cnt` increments.
    - When `cnt` reaches `DEBOUNCE_CYCLES-1`, `db` flips and `cnt` is forced to 0.
  - Rising edge of `db` produces a press event. Falling edges produce nothing.
- FSM states IDLE, RUNNING, PAUSED:
  - IDLE + start/stop press -> RUNNING.
  - RUNNING + start/stop press -> PAUSED.
  - PAUSED + start/stop press -> RUNNING.
  - Any state + reset-button press -> IDLE, with `clear` asserted.
- `running` = (state == RUNNING), registered.
- Simultaneous start/stop press and reset-button press in the same cycle: clear wins. Result: state IDLE, `clear`=1, `start_stop_pulse`=1, no transition to RUNNING.
- Reset-button press while already IDLE still pulses `clear`.
- Counter widths: `$clog2` of the respective parameter; a counter never wraps.
- Reset values:
  - `running`=0, `clear`=0, `start_stop_pulse`=0, `state`=IDLE.
  - Synchroniser flops, `db`, and all counters = 0.
- Reset asserted mid-debounce or mid-hold discards the partial count. A button still held when reset releases is accepted as a new press after the full debounce time.

## Timing
- The raw input changes and stays stable from before edge N.
- Synchronised value is visible after edge N+1.
- `db` flips at edge N+1+`DEBOUNCE_CYCLES`.
- `start_stop_pulse` and `clear` are high for exactly one cycle, starting at edge N+2+`DEBOUNCE_CYCLES`.
- `state` and `running` update at that same edge.
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no event.
- Minimum spacing between two accepted events on one button: 2×`DEBOUNCE_CYCLES` cycles (press plus release).

## Configuration
- `STOPWATCH_LONG_PRESS_EN` defined:
  - A hold counter on the start/stop path counts while that button's `db`=1.
  - At `LONG_PRESS_CYCLES` held cycles, the block pulses `clear` once and forces IDLE. Timing is identical to a reset-button press.
  - Fires at most once per press; the counter clears when `db` falls.
  - The initial press still toggles as normal before the long-press fires.
- `STOPWATCH_LONG_PRESS_EN` undefined: no hold counter; holding start/stop has no effect beyond the initial press.

## Structure
- Shared package `stopwatch_pkg` holds:
  - State enum `sw_state_t` (IDLE/RUNNING/PAUSED, 2-bit).
  - Default constants `SW_DEBOUNCE_CYCLES` and `SW_LONG_PRESS_CYCLES`.
- Sub-module `button_debounce` (synchroniser + debouncer + rise pulse; parameter `DEBOUNCE_CYCLES`), instantiated once per button.
- FSM, output registers and the optional long-press counter live in `stopwatch_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Reset for 3 cycles -> `state`=0, `running`=0, `clear`=0, `start_stop_pulse`=0.
- Clean start/stop press held 10 cycles from edge N -> single `start_stop_pulse` at edge N+6; `state`=1 and `running`=1 from N+6. A second identical press -> `state`=2, `running`=0.
- Start/stop toggling 1,0,1,0 every 2 cycles, then stable high -> exactly one pulse, at 6 cycles after the last transition.
- Reset button and start/stop pressed on the same cycle while RUNNING -> one-cycle `clear`, `state`=0, `running`=0.
- Synchronous `reset` asserted 2 cycles into a debounce -> no pulse. A button held through reset release -> pulse 6 cycles after release.
- With `STOPWATCH_LONG_PRESS_EN`, start/stop held 40 cycles from IDLE:
  - RUNNING at edge N+6.
  - `clear` pulse and IDLE 20 cycles after `db` rose.
  - No further events, including on release.
- Without `STOPWATCH_LONG_PRESS_EN`, the same 40-cycle hold leaves `state`=1.
